conv_addr_sequencer: RTL and testbench
======================================

# conv_addr_sequencer

Loop-nest sequencer for the single-MAC convolution datapath. It walks the output feature map and, for every output pixel and channel, generates the read addresses for the on-chip input and kernel memories. It also drives the operand-register write enables, the MAC control flags and the output coordinate tags, all pipeline-aligned. It replaces the fixed read address of the internal memories and off-loads sequencing from the top-level controller FSM, which only issues `start` and consumes `done`.

## Interface
Parameters:
- FEATURE_MAP_WIDTH, 4: output/input map width W (same-size convolution).
- FEATURE_MAP_HEIGHT, 4: map height H.
- INPUT_NB_CHANNELS, 2: C_IN.
- OUTPUT_NB_CHANNELS, 2: C_OUT.
- KERNEL_SIZE, 3: K, odd only; pad P = (K-1)/2.
- IN_ADDR_WIDTH, 15: input memory address width; W*H*C_IN <= 2^IN_ADDR_WIDTH.
- K_ADDR_WIDTH, 9: kernel memory address width; C_OUT*C_IN*K*K <= 2^K_ADDR_WIDTH.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_in  in  1  reset, synchronous, active-high.
- start  in  1  single-cycle start request, sampled only in IDLE.
- hold  in  1  stall request; freezes the issue stage only.
- busy  out  1  high from the first issue cycle until the last output_valid cycle.
- done  out  1  one-cycle pulse after the last output_valid.
- in_read_en  out  1 / in_read_addr  out  IN_ADDR_WIDTH  input memory read.
- k_read_en  out  1 / k_read_addr  out  K_ADDR_WIDTH  kernel memory read.
- write_a, write_b  out  1  load operand registers a and b.
- a_zero  out  1  with write_a: load 0 into a (padding).
- mac_valid, mac_accumulate_internal, mac_accumulate_with_0  out  1  MAC control.
- output_valid  out  1; output_x  out  $clog2(W); output_y  out  $clog2(H); output_ch  out  $clog2(C_OUT).

## Operation
- Counters, outer to inner: y, x, co, ci, ky, kx. Each wraps to 0 at its bound and carries into the next outer counter.
- One issue (term) per non-held RUN cycle. The term count per pixel-channel is N = C_IN*K*K.
- iy = y+ky-P and ix = x+kx-P are computed signed, one bit wider than the counters.
- In-bounds term (0<=iy<H, 0<=ix<W): in_read_en=1, in_read_addr=((iy*W+ix)*C_IN+ci).
- Out-of-bounds term: in_read_en=0, in_read_addr=0, and a_zero is flagged for that term.
- Every term: k_read_en=1, k_read_addr=(((co*C_IN+ci)*K+ky)*K+kx).
- Flags per term: `first` is set when ci=ky=kx=0. `last` is set when ci=C_IN-1, ky=kx=K-1.
- `first` term: mac_accumulate_with_0=1 and mac_accumulate_internal=0.
- Other terms: mac_accumulate_with_0=0 and mac_accumulate_internal=1.
- `last` term: tags output_valid together with the x, y and co of the term.
- States:
  - IDLE: start goes to RUN.
  - RUN: after issuing the final term (y=H-1, x=W-1, co=C_OUT-1, last) goes to DRAIN.
  - DRAIN: waits 3 cycles for the pipeline to empty, then goes to DONE.
  - DONE: one cycle with done=1, then goes to IDLE.
- start outside IDLE is ignored. hold in IDLE, DRAIN or DONE has no effect.
- hold in RUN: no issue that cycle (read enables 0, counters frozen). Terms already in flight continue to drain.
- Reset, including mid-operation: state IDLE, all counters and pipeline valids 0.

## Timing
- All outputs are registered. All outputs are 0 after reset and while IDLE.
- Issue stage, cycle t: in/k read enables and addresses. Memory read latency is 1 cycle.
- t+1: write_a, write_b, and a_zero if the term was padded.
- t+2: mac_valid plus the accumulate flags.
- t+3: output_valid plus output_x/y/ch, for `last` terms only. The MAC output is valid in the same cycle.
- start sampled at edge of cycle 0 gives the first issue at cycle 1. Issues are back-to-back with no bubbles unless hold is high.
- Total issue cycles without hold: W*H*C_OUT*N. busy stays high until the final output_valid; done pulses the next cycle with busy=0.
- Held cycles add 1:1 to latency. Output tags are never duplicated or dropped.
- The final term with hold asserted in the same cycle is not issued until hold drops.

## Test plan
- Default params, start at cycle 0, no hold:
  - cycle 1: in_read_en=0 (iy=-1), k_read_addr=0.
  - cycle 2: a_zero=1 with write_a=1.
  - cycle 5 (ky=1, kx=1): in_read_en=1, in_read_addr=0.
  - first output_valid at cycle 21 with (x,y,ch)=(0,0,0).
  - 576 issues total; last output_valid at cycle 579; done=1 at cycle 580.
- Flag check, pixel (1,1) co=1: the issue with ci=1, ky=2, kx=2 gives k_read_addr=35 and in_read_addr=((2*4+2)*2+1)=21. mac_accumulate_with_0 is high exactly once per 18 mac_valid pulses.
- hold high cycles 5–7: no issues in cycles 5–7; first output_valid moves to cycle 24; sequence of addresses unchanged.
- rst_in asserted at cycle 100 mid-RUN: next cycle all outputs 0, busy=0, no done. A new start at cycle 110 restarts from (0,0,0); first output_valid at cycle 131.
- start pulsed again at cycle 50 during RUN: ignored. Exactly 576 issues and one done pulse.
- Boundary corner pixel (3,3) with ky=2: iy=4 is out of bounds, so in_read_en=0 and a_zero=1. No in_read_addr >= 32 ever appears.

Source files
------------

// File: rtl/conv_addr_sequencer.sv
// conv_addr_sequencer: loop-nest sequencer for the single-MAC convolution
// datapath. It walks y, x, co, ci, ky, kx and issues one memory-read term per
// non-held RUN cycle. Operand-load, MAC and output-tag controls follow the
// term down a pipeline at fixed offsets of +1, +2 and +3 cycles.
module conv_addr_sequencer #(
  parameter int FEATURE_MAP_WIDTH  = 4,
  parameter int FEATURE_MAP_HEIGHT = 4,
  parameter int INPUT_NB_CHANNELS  = 2,
  parameter int OUTPUT_NB_CHANNELS = 2,
  parameter int KERNEL_SIZE        = 3,
  parameter int IN_ADDR_WIDTH      = 15,
  parameter int K_ADDR_WIDTH       = 9
) (
  input  logic                                    clk,
  input  logic                                    rst_in,
  input  logic                                    start,
  input  logic                                    hold,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    in_read_en,
  output logic [IN_ADDR_WIDTH-1:0]                in_read_addr,
  output logic                                    k_read_en,
  output logic [K_ADDR_WIDTH-1:0]                 k_read_addr,
  output logic                                    write_a,
  output logic                                    write_b,
  output logic                                    a_zero,
  output logic                                    mac_valid,
  output logic                                    mac_accumulate_internal,
  output logic                                    mac_accumulate_with_0,
  output logic                                    output_valid,
  output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]    output_x,
  output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]   output_y,
  output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]   output_ch
);

  localparam int W   = FEATURE_MAP_WIDTH;
  localparam int H   = FEATURE_MAP_HEIGHT;
  localparam int CI  = INPUT_NB_CHANNELS;
  localparam int CO  = OUTPUT_NB_CHANNELS;
  localparam int K   = KERNEL_SIZE;
  localparam int P   = (K - 1) / 2;
  localparam int XW  = $clog2(W);
  localparam int YW  = $clog2(H);
  localparam int OW  = $clog2(CO);
  localparam int CIW = (CI > 1) ? $clog2(CI) : 1;
  localparam int KW  = (K > 1) ? $clog2(K) : 1;
  localparam int MW  = (XW > YW) ? ((XW > KW) ? XW : KW) : ((YW > KW) ? YW : KW);
  // One bit of headroom for y+ky plus a sign bit.
  localparam int SW  = MW + 2;

  localparam logic signed [SW-1:0] ZERO_S = SW'(0);
  localparam logic signed [SW-1:0] PAD_S  = SW'(P);
  localparam logic signed [SW-1:0] W_S    = SW'(W);
  localparam logic signed [SW-1:0] H_S    = SW'(H);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t state_q, state_d;
  logic [1:0]     drain_q, drain_d;
  logic [YW-1:0]  y_q, y_d;
  logic [XW-1:0]  x_q, x_d;
  logic [OW-1:0]  co_q, co_d;
  logic [CIW-1:0] ci_q, ci_d;
  logic [KW-1:0]  ky_q, ky_d, kx_q, kx_d;

  logic                    issue_s, in_bounds_s, first_s, last_s, final_s;
  logic signed [SW-1:0]    iy_s, ix_s;
  logic [IN_ADDR_WIDTH-1:0] in_lin_s;
  logic [K_ADDR_WIDTH-1:0]  k_lin_s;

  // Issue stage (cycle t)
  logic                     in_read_en_q, in_read_en_d, k_read_en_q, k_read_en_d;
  logic [IN_ADDR_WIDTH-1:0] in_read_addr_q, in_read_addr_d;
  logic [K_ADDR_WIDTH-1:0]  k_read_addr_q, k_read_addr_d;
  logic                     pad1_q, pad1_d, first1_q, first1_d, last1_q, last1_d;
  logic [XW-1:0]            x1_q, x1_d, x2_q, x2_d, x3_q, x3_d;
  logic [YW-1:0]            y1_q, y1_d, y2_q, y2_d, y3_q, y3_d;
  logic [OW-1:0]            co1_q, co1_d, co2_q, co2_d, co3_q, co3_d;
  // Operand load stage (t+1)
  logic write_a_q, write_a_d, write_b_q, write_b_d, a_zero_q, a_zero_d;
  logic first2_q, first2_d, last2_q, last2_d;
  // MAC stage (t+2)
  logic mac_valid_q, mac_valid_d, acc_int_q, acc_int_d, acc0_q, acc0_d;
  logic last3_q, last3_d;
  // Output tag stage (t+3)
  logic          output_valid_q, output_valid_d;
  logic [XW-1:0] output_x_q, output_x_d;
  logic [YW-1:0] output_y_q, output_y_d;
  logic [OW-1:0] output_ch_q, output_ch_d;
  logic          busy_q, busy_d, done_q, done_d;

  // Decode the current loop position into a term: padding test, addresses, flags.
  always_comb begin
    issue_s     = (state_q == S_RUN) && !hold;
    iy_s        = $signed({{(SW-YW){1'b0}}, y_q}) + $signed({{(SW-KW){1'b0}}, ky_q}) - PAD_S;
    ix_s        = $signed({{(SW-XW){1'b0}}, x_q}) + $signed({{(SW-KW){1'b0}}, kx_q}) - PAD_S;
    in_bounds_s = (iy_s >= ZERO_S) && (iy_s < H_S) && (ix_s >= ZERO_S) && (ix_s < W_S);
    first_s     = (ci_q == {CIW{1'b0}}) && (ky_q == {KW{1'b0}}) && (kx_q == {KW{1'b0}});
    last_s      = (ci_q == CIW'(CI - 1)) && (ky_q == KW'(K - 1)) && (kx_q == KW'(K - 1));
    final_s     = last_s && (co_q == OW'(CO - 1)) && (x_q == XW'(W - 1)) && (y_q == YW'(H - 1));
    in_lin_s    = IN_ADDR_WIDTH'((32'(iy_s) * 32'(W) + 32'(ix_s)) * 32'(CI) + 32'(ci_q));
    k_lin_s     = K_ADDR_WIDTH'(((32'(co_q) * 32'(CI) + 32'(ci_q)) * 32'(K) + 32'(ky_q)) * 32'(K)
                                + 32'(kx_q));
  end

  // Next state of the FSM and of the loop counters (innermost kx carries outward).
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
        else       state_d = S_IDLE;
      end
      S_RUN: begin
        if (issue_s && final_s) begin
          state_d = S_DRAIN;
          drain_d = 2'd0;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DRAIN: begin
        if (drain_q == 2'd2) state_d = S_DONE;
        else                 drain_d = drain_q + 2'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    y_d = y_q; x_d = x_q; co_d = co_q; ci_d = ci_q; ky_d = ky_q; kx_d = kx_q;
    if (issue_s) begin
      if (kx_q != KW'(K - 1)) kx_d = kx_q + KW'(1);
      else begin
        kx_d = {KW{1'b0}};
        if (ky_q != KW'(K - 1)) ky_d = ky_q + KW'(1);
        else begin
          ky_d = {KW{1'b0}};
          if (ci_q != CIW'(CI - 1)) ci_d = ci_q + CIW'(1);
          else begin
            ci_d = {CIW{1'b0}};
            if (co_q != OW'(CO - 1)) co_d = co_q + OW'(1);
            else begin
              co_d = {OW{1'b0}};
              if (x_q != XW'(W - 1)) x_d = x_q + XW'(1);
              else begin
                x_d = {XW{1'b0}};
                if (y_q != YW'(H - 1)) y_d = y_q + YW'(1);
                else                   y_d = {YW{1'b0}};
              end
            end
          end
        end
      end
    end else begin
      kx_d = kx_q;
    end
  end

  // Pipeline next values: each stage forwards the term's flags and coordinates.
  always_comb begin
    in_read_en_d   = issue_s && in_bounds_s;
    in_read_addr_d = (issue_s && in_bounds_s) ? in_lin_s : {IN_ADDR_WIDTH{1'b0}};
    k_read_en_d    = issue_s;
    k_read_addr_d  = issue_s ? k_lin_s : {K_ADDR_WIDTH{1'b0}};
    pad1_d         = issue_s && !in_bounds_s;
    first1_d       = issue_s && first_s;
    last1_d        = issue_s && last_s;
    x1_d           = issue_s ? x_q  : {XW{1'b0}};
    y1_d           = issue_s ? y_q  : {YW{1'b0}};
    co1_d          = issue_s ? co_q : {OW{1'b0}};

    write_a_d = k_read_en_q;
    write_b_d = k_read_en_q;
    a_zero_d  = pad1_q;
    first2_d  = first1_q;
    last2_d   = last1_q;
    x2_d      = x1_q;
    y2_d      = y1_q;
    co2_d     = co1_q;

    mac_valid_d = write_a_q;
    acc0_d      = write_a_q && first2_q;
    acc_int_d   = write_a_q && !first2_q;
    last3_d     = last2_q;
    x3_d        = x2_q;
    y3_d        = y2_q;
    co3_d       = co2_q;

    output_valid_d = last3_q;
    output_x_d     = last3_q ? x3_q  : {XW{1'b0}};
    output_y_d     = last3_q ? y3_q  : {YW{1'b0}};
    output_ch_d    = last3_q ? co3_q : {OW{1'b0}};

    if (state_q == S_DONE) busy_d = 1'b0;
    else if (issue_s)      busy_d = 1'b1;
    else                   busy_d = busy_q;
    done_d = (state_q == S_DONE);
  end

  // FSM state and loop counters.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q <= S_IDLE;
      drain_q <= 2'd0;
      y_q     <= {YW{1'b0}};
      x_q     <= {XW{1'b0}};
      co_q    <= {OW{1'b0}};
      ci_q    <= {CIW{1'b0}};
      ky_q    <= {KW{1'b0}};
      kx_q    <= {KW{1'b0}};
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      y_q     <= y_d;
      x_q     <= x_d;
      co_q    <= co_d;
      ci_q    <= ci_d;
      ky_q    <= ky_d;
      kx_q    <= kx_d;
    end
  end

  // Pipeline registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst_in) begin
      in_read_en_q   <= 1'b0;
      in_read_addr_q <= {IN_ADDR_WIDTH{1'b0}};
      k_read_en_q    <= 1'b0;
      k_read_addr_q  <= {K_ADDR_WIDTH{1'b0}};
      pad1_q <= 1'b0; first1_q <= 1'b0; last1_q <= 1'b0;
      x1_q <= {XW{1'b0}}; y1_q <= {YW{1'b0}}; co1_q <= {OW{1'b0}};
      write_a_q <= 1'b0; write_b_q <= 1'b0; a_zero_q <= 1'b0;
      first2_q <= 1'b0; last2_q <= 1'b0;
      x2_q <= {XW{1'b0}}; y2_q <= {YW{1'b0}}; co2_q <= {OW{1'b0}};
      mac_valid_q <= 1'b0; acc0_q <= 1'b0; acc_int_q <= 1'b0; last3_q <= 1'b0;
      x3_q <= {XW{1'b0}}; y3_q <= {YW{1'b0}}; co3_q <= {OW{1'b0}};
      output_valid_q <= 1'b0;
      output_x_q <= {XW{1'b0}}; output_y_q <= {YW{1'b0}}; output_ch_q <= {OW{1'b0}};
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      in_read_en_q   <= in_read_en_d;
      in_read_addr_q <= in_read_addr_d;
      k_read_en_q    <= k_read_en_d;
      k_read_addr_q  <= k_read_addr_d;
      pad1_q <= pad1_d; first1_q <= first1_d; last1_q <= last1_d;
      x1_q <= x1_d; y1_q <= y1_d; co1_q <= co1_d;
      write_a_q <= write_a_d; write_b_q <= write_b_d; a_zero_q <= a_zero_d;
      first2_q <= first2_d; last2_q <= last2_d;
      x2_q <= x2_d; y2_q <= y2_d; co2_q <= co2_d;
      mac_valid_q <= mac_valid_d; acc0_q <= acc0_d; acc_int_q <= acc_int_d; last3_q <= last3_d;
      x3_q <= x3_d; y3_q <= y3_d; co3_q <= co3_d;
      output_valid_q <= output_valid_d;
      output_x_q <= output_x_d; output_y_q <= output_y_d; output_ch_q <= output_ch_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy                    = busy_q;
  assign done                    = done_q;
  assign in_read_en              = in_read_en_q;
  assign in_read_addr            = in_read_addr_q;
  assign k_read_en               = k_read_en_q;
  assign k_read_addr             = k_read_addr_q;
  assign write_a                 = write_a_q;
  assign write_b                 = write_b_q;
  assign a_zero                  = a_zero_q;
  assign mac_valid               = mac_valid_q;
  assign mac_accumulate_internal = acc_int_q;
  assign mac_accumulate_with_0   = acc0_q;
  assign output_valid            = output_valid_q;
  assign output_x                = output_x_q;
  assign output_y                = output_y_q;
  assign output_ch               = output_ch_q;

endmodule

// File: tb/tb_conv_addr_sequencer.sv
// Self-checking bench for conv_addr_sequencer (default parameters).
// A term-list reference model predicts every output on every cycle; a table of
// directed runs checks the headline timing, and hand-written checks cover the
// corner cases (padding, flag terms, reset mid-run).
module tb_conv_addr_sequencer;

  localparam int W = 4, H = 4, CI = 2, CO = 2, K = 3, P = 1;
  localparam int N = CI * K * K;
  localparam int NT = W * H * CO * N;
  localparam int MAXC = 1400;

  typedef struct packed {
    logic        in_en;
    logic [14:0] in_addr;
    logic        k_en;
    logic [8:0]  k_addr;
    logic        wa, wb, az, mv, ai, a0, ov;
    logic [1:0]  ox, oy;
    logic        och;
    logic        busy, done;
  } out_t;

  typedef struct {
    int hold_lo, hold_hi, start2;
    int first_ov, last_ov, done_c, issues;
  } vec_t;

  logic clk = 1'b0, rst_in = 1'b1, start = 1'b0, hold = 1'b0;
  logic busy, done, in_read_en, k_read_en, write_a, write_b, a_zero;
  logic mac_valid, mac_accumulate_internal, mac_accumulate_with_0, output_valid;
  logic [14:0] in_read_addr;
  logic [8:0]  k_read_addr;
  logic [1:0]  output_x, output_y;
  logic [0:0]  output_ch;

  conv_addr_sequencer dut (
    .clk(clk), .rst_in(rst_in), .start(start), .hold(hold),
    .busy(busy), .done(done),
    .in_read_en(in_read_en), .in_read_addr(in_read_addr),
    .k_read_en(k_read_en), .k_read_addr(k_read_addr),
    .write_a(write_a), .write_b(write_b), .a_zero(a_zero),
    .mac_valid(mac_valid), .mac_accumulate_internal(mac_accumulate_internal),
    .mac_accumulate_with_0(mac_accumulate_with_0),
    .output_valid(output_valid), .output_x(output_x), .output_y(output_y),
    .output_ch(output_ch)
  );

  always #5 clk = ~clk;

  int   tests = 0, fails = 0;
  out_t exp_tr [MAXC];
  out_t act_tr [MAXC];
  bit   hold_pat [MAXC];
  int   first_ov, last_ov, done_c, done_cnt, issues, mv_cnt, a0_cnt, max_in_addr;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_model();
    for (int c = 0; c < MAXC; c++) begin
      exp_tr[c]   = '0;
      act_tr[c]   = '0;
      hold_pat[c] = 1'b0;
    end
  endtask

  // Places all NT terms after a start sampled at edge s, skipping held cycles,
  // discarding anything at or after reset edge r. Returns the done cycle (-1 if cut).
  function automatic int model_fill(input int s, input int r);
    int c = s, f = -1, lc = -1;
    bit cut = 1'b0;
    for (int i = 0; i < NT; i++) begin
      int pc, t, ci, ky, kx, co, pix, x, y, iy, ix;
      bit inb;
      c++;
      while (c < r && c < MAXC - 6 && hold_pat[c]) c++;
      if (c >= r || c >= MAXC - 6) begin cut = 1'b1; break; end
      pc = i / N; t = i % N;
      ci = t / (K * K); ky = (t % (K * K)) / K; kx = t % K;
      co = pc % CO; pix = pc / CO; x = pix % W; y = pix / W;
      iy = y + ky - P; ix = x + kx - P;
      inb = (iy >= 0) && (iy < H) && (ix >= 0) && (ix < W);
      exp_tr[c].in_en   = inb;
      exp_tr[c].in_addr = inb ? 15'((iy * W + ix) * CI + ci) : 15'd0;
      exp_tr[c].k_en    = 1'b1;
      exp_tr[c].k_addr  = 9'(((co * CI + ci) * K + ky) * K + kx);
      if (c + 1 < r) begin
        exp_tr[c+1].wa = 1'b1; exp_tr[c+1].wb = 1'b1; exp_tr[c+1].az = !inb;
      end
      if (c + 2 < r) begin
        exp_tr[c+2].mv = 1'b1; exp_tr[c+2].a0 = (t == 0); exp_tr[c+2].ai = (t != 0);
      end
      if (c + 3 < r && t == N - 1) begin
        exp_tr[c+3].ov = 1'b1; exp_tr[c+3].ox = 2'(x); exp_tr[c+3].oy = 2'(y);
        exp_tr[c+3].och = 1'(co);
      end
      if (f < 0) f = c;
      lc = c;
    end
    if (f >= 0) begin
      for (int cc = f; cc <= (cut ? r - 1 : lc + 3); cc++) exp_tr[cc].busy = 1'b1;
    end
    if (cut) return -1;
    exp_tr[lc+4].done = 1'b1;
    return lc + 4;
  endfunction

  // Applies start at edge 0 and runs cycles 1..end_c, comparing each cycle against the model.
  task automatic run_case(input int start2, input int rst_c, input int restart_c,
                          input int meas_from, input int end_c);
    out_t a;
    rst_in = 1'b1; start = 1'b0; hold = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_in = 1'b0;
    a = {in_read_en, in_read_addr, k_read_en, k_read_addr, write_a, write_b, a_zero,
         mac_valid, mac_accumulate_internal, mac_accumulate_with_0, output_valid,
         output_x, output_y, output_ch, busy, done};
    check(a == '0, "reset_state", 64'(a), 64'(0));
    first_ov = -1; last_ov = -1; done_c = -1; done_cnt = 0; issues = 0;
    mv_cnt = 0; a0_cnt = 0; max_in_addr = 0;
    start = 1'b1;
    for (int c = 0; c <= end_c; c++) begin
      if (c > 0) begin
        start  = (c == start2) || (c == restart_c);
        hold   = hold_pat[c];
        rst_in = (c == rst_c);
      end
      @(posedge clk);
      #1;
      a = {in_read_en, in_read_addr, k_read_en, k_read_addr, write_a, write_b, a_zero,
           mac_valid, mac_accumulate_internal, mac_accumulate_with_0, output_valid,
           output_x, output_y, output_ch, busy, done};
      act_tr[c] = a;
      check(a == exp_tr[c], $sformatf("trace_cycle_%0d", c), 64'(a), 64'(exp_tr[c]));
      if (c >= meas_from) begin
        if (a.ov && first_ov < 0) first_ov = c;
        if (a.ov) last_ov = c;
        if (a.done) begin done_cnt++; done_c = c; end
        if (a.k_en) issues++;
        if (a.mv) mv_cnt++;
        if (a.a0) a0_cnt++;
        if (a.in_en && int'(a.in_addr) > max_in_addr) max_in_addr = int'(a.in_addr);
      end
    end
    start = 1'b0; hold = 1'b0; rst_in = 1'b0;
  endtask

  vec_t vecs [3];

  initial begin
    int d, d2;
    vecs[0] = '{hold_lo: 0, hold_hi: -1, start2: -1, first_ov: 21, last_ov: 579, done_c: 580, issues: 576};
    vecs[1] = '{hold_lo: 5, hold_hi: 7,  start2: -1, first_ov: 24, last_ov: 582, done_c: 583, issues: 576};
    vecs[2] = '{hold_lo: 0, hold_hi: -1, start2: 50, first_ov: 21, last_ov: 579, done_c: 580, issues: 576};

    for (int v = 0; v < 3; v++) begin
      clear_model();
      for (int c = vecs[v].hold_lo; c <= vecs[v].hold_hi; c++) hold_pat[c] = 1'b1;
      d = model_fill(0, MAXC);
      run_case(vecs[v].start2, -1, -1, 0, d + 3);
      check(first_ov == vecs[v].first_ov, $sformatf("v%0d_first_ov", v), 64'(first_ov), 64'(vecs[v].first_ov));
      check(last_ov == vecs[v].last_ov, $sformatf("v%0d_last_ov", v), 64'(last_ov), 64'(vecs[v].last_ov));
      check(done_c == vecs[v].done_c, $sformatf("v%0d_done_cycle", v), 64'(done_c), 64'(vecs[v].done_c));
      check(issues == vecs[v].issues, $sformatf("v%0d_issues", v), 64'(issues), 64'(vecs[v].issues));
      check(done_cnt == 1, $sformatf("v%0d_done_pulses", v), 64'(done_cnt), 64'(1));
      check(max_in_addr < 32, $sformatf("v%0d_max_in_addr", v), 64'(max_in_addr), 64'(31));
      if (v == 0) begin
        check(act_tr[1].in_en == 1'b0, "c1_in_en_pad", 64'(act_tr[1].in_en), 64'(0));
        check(act_tr[1].k_en == 1'b1 && act_tr[1].k_addr == 9'd0, "c1_k_addr",
              64'(act_tr[1].k_addr), 64'(0));
        check(act_tr[2].wa == 1'b1 && act_tr[2].az == 1'b1, "c2_a_zero",
              64'({act_tr[2].wa, act_tr[2].az}), 64'(3));
        check(act_tr[5].in_en == 1'b1 && act_tr[5].in_addr == 15'd0, "c5_center_tap",
              64'({act_tr[5].in_en, act_tr[5].in_addr}), 64'(16'h8000));
        check(act_tr[216].in_addr == 15'd21 && act_tr[216].k_addr == 9'd35, "pix11_co1_last",
              64'({act_tr[216].in_addr, act_tr[216].k_addr}), 64'({15'd21, 9'd35}));
        check(act_tr[548].in_en == 1'b0 && act_tr[549].az == 1'b1, "corner33_ky2_pad",
              64'({act_tr[548].in_en, act_tr[549].az}), 64'(1));
        check(a0_cnt * N == mv_cnt, "acc_with_0_ratio", 64'(a0_cnt), 64'(mv_cnt / N));
      end
    end

    // Reset at edge 100 mid-run, new start at edge 110.
    clear_model();
    d = model_fill(0, 100);
    d2 = model_fill(110, MAXC);
    run_case(-1, 100, 110, 100, d2 + 3);
    check(act_tr[100] == '0, "rst_outputs_zero", 64'(act_tr[100]), 64'(0));
    check(first_ov == 131, "restart_first_ov", 64'(first_ov), 64'(131));
    check(issues == NT, "restart_issues", 64'(issues), 64'(NT));
    check(done_cnt == 1 && d == -1, "restart_done_pulses", 64'(done_cnt), 64'(1));

    // Randomized hold pattern against the model.
    for (int r = 0; r < 2; r++) begin
      clear_model();
      for (int c = 1; c < MAXC; c++) hold_pat[c] = ($urandom_range(0, 4) == 0);
      d = model_fill(0, MAXC);
      if (d < 0) begin
        check(1'b0, "rand_model_budget", 64'(d), 64'(0));
      end else begin
        run_case(-1, -1, -1, 0, d + 3);
        check(issues == NT, $sformatf("rand%0d_issues", r), 64'(issues), 64'(NT));
        check(done_cnt == 1, $sformatf("rand%0d_done_pulses", r), 64'(done_cnt), 64'(1));
        check(a0_cnt * N == mv_cnt, $sformatf("rand%0d_acc0_ratio", r), 64'(a0_cnt), 64'(mv_cnt / N));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
